// File: rtl/matrix_scratchpad_pkg.sv
// Shared constants for the matrix scratchpad: data width, engine memory opcodes,
// parameter/control word addresses and the arbitration FSM state type.
`ifndef TYPE_BW
`define TYPE_BW 32
`endif
`ifndef MEM_NONE
`define MEM_NONE  2'b00
`define MEM_READ  2'b01
`define MEM_WRITE 2'b11
`endif

package matrix_scratchpad_pkg;

  localparam int unsigned DW = `TYPE_BW;

  localparam logic [1:0] MEM_NONE  = `MEM_NONE;
  localparam logic [1:0] MEM_READ  = `MEM_READ;
  localparam logic [1:0] MEM_WRITE = `MEM_WRITE;

  localparam logic [31:0] PARAM_OP_ADDR = 32'd0;
  localparam logic [31:0] PARAM_WA_ADDR = 32'd1;
  localparam logic [31:0] PARAM_HA_ADDR = 32'd2;
  localparam logic [31:0] PARAM_WB_ADDR = 32'd3;
  localparam logic [31:0] PARAM_HB_ADDR = 32'd4;
  localparam logic [31:0] CTRL_ADDR     = 32'd5;
  localparam logic [31:0] MATRIX_BASE   = 32'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENG  = 2'd1,
    ST_HOST = 2'd2
  } state_e;

  // Opcode 10 is reserved and behaves like "no request".
  function automatic logic is_eng_req(input logic [1:0] op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/matrix_scratchpad_if.sv
// Host load/readback port plus engine memory/handshake port of the scratchpad.
interface matrix_scratchpad_if #(parameter int unsigned DW = 32);
  logic          host_req;
  logic          host_we;
  logic [31:0]   host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic [1:0]    eng_mem_operation;
  logic [31:0]   eng_addr;
  logic [DW-1:0] eng_wdata;
  logic [DW-1:0] eng_rdata;
  logic          eng_opdone;
  logic          eng_enable;
  logic          eng_done;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    output eng_mem_operation, eng_addr, eng_wdata, eng_done,
    input  eng_rdata, eng_opdone, eng_enable
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    input  eng_mem_operation, eng_addr, eng_wdata, eng_done,
    output eng_rdata, eng_opdone, eng_enable
  );
endinterface

// File: rtl/matrix_scratchpad_spram.sv
// Synchronous single-port RAM with registered read; contents are never reset.
module matrix_spram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read data register only updates on reads, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/matrix_scratchpad.sv
// Shared operand/result memory for the matrix engine: engine-priority arbiter with
// fixed access latency, host load/readback, and the go/done control/status word.
module matrix_scratchpad
  import matrix_scratchpad_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ACCESS_LAT = 2
) (
  input logic                clk,
  input logic                reset,
  matrix_scratchpad_if.slave bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT    = 4'(ACCESS_LAT);
  localparam logic [3:0]  LAT_M1 = 4'(ACCESS_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lat_we_q, lat_we_d;
  logic [31:0]   lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          host_ack_q, host_ack_d;
  logic          eng_ack_q, eng_ack_d;
  logic [DW-1:0] host_hold_q, eng_hold_q;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          eng_req_s, grant_s, abort_s, fire_s, last_s, go_s;
  logic          acc_we_s, acc_host_s, acc_in_range_s, lat_in_range_s;
  logic [31:0]   acc_addr_s;
  logic [DW-1:0] acc_wdata_s, ram_rdata_s, status_s;
  logic [DW-1:0] host_rdata_s, eng_rdata_s;
  logic          ram_en_s;

  assign eng_req_s = is_eng_req(bus.eng_mem_operation);

  // Arbitration, latency count and abort; the "acc" signals steer the RAM port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    grant_s     = 1'b0;
    abort_s     = 1'b0;
    acc_we_s    = lat_we_q;
    acc_addr_s  = lat_addr_q;
    acc_wdata_s = lat_wdata_q;
    acc_host_s  = (state_q == ST_HOST);
    case (state_q)
      ST_IDLE: begin
        if (eng_req_s) begin
          state_d     = ST_ENG;
          grant_s     = 1'b1;
          acc_we_s    = (bus.eng_mem_operation == MEM_WRITE);
          acc_addr_s  = bus.eng_addr;
          acc_wdata_s = bus.eng_wdata;
          acc_host_s  = 1'b0;
        end else if (bus.host_req) begin
          state_d     = ST_HOST;
          grant_s     = 1'b1;
          acc_we_s    = bus.host_we;
          acc_addr_s  = bus.host_addr;
          acc_wdata_s = bus.host_wdata;
          acc_host_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        if (grant_s) begin
          cnt_d       = 4'd1;
          lat_we_d    = acc_we_s;
          lat_addr_d  = acc_addr_s;
          lat_wdata_d = acc_wdata_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ENG, ST_HOST: begin
        if (cnt_q == LAT) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_ENG) &&
                     (!eng_req_s || (bus.eng_addr != lat_addr_q))) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completion, deferred RAM write, control/status word and read-data steering.
  always_comb begin
    last_s = ((state_q == ST_ENG) || (state_q == ST_HOST)) && (cnt_q == LAT);
    if (ACCESS_LAT == 1) begin
      fire_s = grant_s;
    end else begin
      fire_s = ((state_q == ST_ENG) || (state_q == ST_HOST)) && !abort_s && (cnt_q == LAT_M1);
    end
    host_ack_d     = fire_s && acc_host_s;
    eng_ack_d      = fire_s && !acc_host_s;
    acc_in_range_s = (acc_addr_s < 32'(DEPTH));
    // Writes land on the edge before the ack so an aborted engine write never reaches the RAM.
    ram_en_s = !reset &&
               ((grant_s && !acc_we_s) ||
                (fire_s && acc_we_s && acc_in_range_s &&
                 !(acc_host_s && (acc_addr_s == CTRL_ADDR))));

    go_s = last_s && (state_q == ST_HOST) && lat_we_q && (lat_addr_q == CTRL_ADDR) &&
           (lat_wdata_q != {DW{1'b0}}) && !busy_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (go_s) begin
      enable_d = 1'b1;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (bus.eng_done && busy_q) begin
      enable_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end else begin
      enable_d = enable_q;
    end

    lat_in_range_s = (lat_addr_q < 32'(DEPTH));
    status_s       = {{(DW-2){1'b0}}, done_q, busy_q};
    if (host_ack_q && !lat_we_q) begin
      if (lat_addr_q == CTRL_ADDR) begin
        host_rdata_s = status_s;
      end else if (lat_in_range_s) begin
        host_rdata_s = ram_rdata_s;
      end else begin
        host_rdata_s = {DW{1'b0}};
      end
    end else begin
      host_rdata_s = host_hold_q;
    end
    if (eng_ack_q && !lat_we_q) begin
      eng_rdata_s = lat_in_range_s ? ram_rdata_s : {DW{1'b0}};
    end else begin
      eng_rdata_s = eng_hold_q;
    end
  end

  // State, latches, pulses and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= {DW{1'b0}};
      host_ack_q  <= 1'b0;
      eng_ack_q   <= 1'b0;
      host_hold_q <= {DW{1'b0}};
      eng_hold_q  <= {DW{1'b0}};
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      host_ack_q  <= host_ack_d;
      eng_ack_q   <= eng_ack_d;
      host_hold_q <= host_rdata_s;
      eng_hold_q  <= eng_rdata_s;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  matrix_spram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk     (clk),
    .en_i    (ram_en_s),
    .we_i    (acc_we_s),
    .addr_i  (acc_addr_s[AW-1:0]),
    .wdata_i (acc_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign bus.host_rdata = host_rdata_s;
  assign bus.host_ack   = host_ack_q;
  assign bus.eng_rdata  = eng_rdata_s;
  assign bus.eng_opdone = eng_ack_q;
  assign bus.eng_enable = enable_q;
endmodule

// File: tb/tb_matrix_scratchpad.sv
// Directed bench for matrix_scratchpad: host and a behavioural engine share one
// initial block; read expectations go through a scoreboard queue.
module tb_matrix_scratchpad;
  import matrix_scratchpad_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LATC  = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] exp_q [$];

  matrix_scratchpad_if #(.DW(DW)) bus ();

  matrix_scratchpad #(.DEPTH(DEPTH), .ACCESS_LAT(LATC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_op(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd,
                         output int lat, output logic [DW-1:0] rd);
    logic got;
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      got = bus.host_ack;
    end
    check("host_ack_seen", {63'd0, got}, 64'd1);
    rd = bus.host_rdata;
    bus.host_req = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] addr, input logic [DW-1:0] wd);
    int lat; logic [DW-1:0] rd;
    host_op(1'b1, addr, wd, lat, rd);
  endtask

  task automatic host_read_chk(input string tag, input logic [31:0] addr, input logic [DW-1:0] exp);
    int lat; logic [DW-1:0] rd;
    exp_q.push_back(exp);
    host_op(1'b0, addr, {DW{1'b0}}, lat, rd);
    check(tag, 64'(rd), 64'(exp_q.pop_front()));
  endtask

  // Leaves the opcode asserted so the caller can chain back-to-back accesses.
  task automatic eng_op(input logic [1:0] op, input logic [31:0] addr, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd);
    logic got;
    bus.eng_mem_operation = op; bus.eng_addr = addr; bus.eng_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.eng_opdone;
    end
    check("eng_opdone_seen", {63'd0, got}, 64'd1);
    rd = bus.eng_rdata;
  endtask

  initial begin
    int lat, e_cyc, h_cyc;
    logic [DW-1:0] rd, e_data, h_data;
    logic [DW-1:0] m [8];
    logic [DW-1:0] c [4];
    logic seen;

    reset = 1'b1;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 32'd0; bus.host_wdata = {DW{1'b0}};
    bus.eng_mem_operation = MEM_NONE; bus.eng_addr = 32'd0; bus.eng_wdata = {DW{1'b0}};
    bus.eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_host_rdata", 64'(bus.host_rdata), 64'd0);
    check("rst_host_ack", {63'd0, bus.host_ack}, 64'd0);
    check("rst_eng_rdata", 64'(bus.eng_rdata), 64'd0);
    check("rst_eng_opdone", {63'd0, bus.eng_opdone}, 64'd0);
    check("rst_eng_enable", {63'd0, bus.eng_enable}, 64'd0);
    reset = 1'b0;

    // Host write then readback with latency measured from the IDLE request cycle.
    host_op(1'b1, 32'd20, 32'd7, lat, rd);
    check("host_wr_lat", 64'(lat), 64'(LATC));
    exp_q.push_back(32'd7);
    host_op(1'b0, 32'd20, 32'd0, lat, rd);
    check("host_rd_lat", 64'(lat), 64'(LATC));
    check("host_rd20", 64'(rd), 64'(exp_q.pop_front()));

    // Same-cycle engine and host requests: engine first, host three cycles later.
    host_write(32'd1, 32'd11);
    host_write(32'd2, 32'd22);
    @(posedge clk); #1;
    bus.eng_mem_operation = MEM_READ; bus.eng_addr = 32'd1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'd2;
    e_cyc = 0; h_cyc = 0; e_data = {DW{1'b0}}; h_data = {DW{1'b0}};
    for (int cy = 1; cy <= 20 && h_cyc == 0; cy++) begin
      @(posedge clk); #1;
      if (bus.eng_opdone) begin
        e_cyc = cy; e_data = bus.eng_rdata; bus.eng_mem_operation = MEM_NONE;
      end
      if (bus.host_ack) begin
        h_cyc = cy; h_data = bus.host_rdata; bus.host_req = 1'b0;
      end
    end
    bus.host_req = 1'b0; bus.eng_mem_operation = MEM_NONE;
    check("tie_eng_cycle", 64'(e_cyc), 64'(LATC));
    check("tie_host_cycle", 64'(h_cyc), 64'(LATC + 3));
    check("tie_eng_data", 64'(e_data), 64'd11);
    check("tie_host_data", 64'(h_data), 64'd22);

    // Engine read@5 withdrawn after one cycle must not complete.
    @(posedge clk); #1;
    bus.eng_mem_operation = MEM_READ; bus.eng_addr = CTRL_ADDR;
    @(posedge clk); #1;
    bus.eng_mem_operation = MEM_NONE;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | bus.eng_opdone;
    end
    check("abort_no_opdone", {63'd0, seen}, 64'd0);
    host_read_chk("abort_status", CTRL_ADDR, 32'd0);

    // Full run: load parameters and operands, start, emulate the engine.
    host_write(PARAM_OP_ADDR, 32'd1);
    host_write(PARAM_WA_ADDR, 32'd2);
    host_write(PARAM_HA_ADDR, 32'd2);
    host_write(PARAM_WB_ADDR, 32'd2);
    host_write(PARAM_HB_ADDR, 32'd2);
    for (int i = 0; i < 8; i++) host_write(MATRIX_BASE + 32'(i), 32'(i + 1));
    host_write(CTRL_ADDR, 32'd1);
    check("go_enable_at_ack", {63'd0, bus.eng_enable}, 64'd0);
    @(posedge clk); #1;
    check("go_enable_after", {63'd0, bus.eng_enable}, 64'd1);
    host_write(CTRL_ADDR, 32'd1);
    check("busy_write_enable", {63'd0, bus.eng_enable}, 64'd1);
    host_read_chk("busy_status", CTRL_ADDR, 32'd1);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back((i == 0) ? 32'd1 : 32'd2);
      eng_op(MEM_READ, 32'(i), {DW{1'b0}}, rd);
      check("eng_param", 64'(rd), 64'(exp_q.pop_front()));
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'(i + 1));
      eng_op(MEM_READ, MATRIX_BASE + 32'(i), {DW{1'b0}}, m[i]);
      check("eng_operand", 64'(m[i]), 64'(exp_q.pop_front()));
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        c[r*2+k] = m[r*2] * m[4+k] + m[r*2+1] * m[6+k];
    for (int i = 0; i < 4; i++) eng_op(MEM_WRITE, 32'd14 + 32'(i), c[i], rd);
    bus.eng_mem_operation = MEM_NONE;
    @(posedge clk); #1;
    check("pre_done_enable", {63'd0, bus.eng_enable}, 64'd1);
    bus.eng_done = 1'b1;
    @(posedge clk); #1;
    bus.eng_done = 1'b0;
    check("done_enable_drop", {63'd0, bus.eng_enable}, 64'd0);
    host_read_chk("c00", 32'd14, 32'd19);
    host_read_chk("c01", 32'd15, 32'd22);
    host_read_chk("c10", 32'd16, 32'd43);
    host_read_chk("c11", 32'd17, 32'd50);
    host_read_chk("done_status", CTRL_ADDR, 32'd2);

    // Out-of-range write is acked but dropped.
    host_write(32'(DEPTH), 32'hAA);
    host_read_chk("oor_read", 32'(DEPTH), 32'd0);
    host_read_chk("oor_word0", 32'd0, 32'd1);

    // Reset during an engine write discards it and drops enable.
    host_write(32'd30, 32'h33);
    host_write(CTRL_ADDR, 32'd1);
    @(posedge clk); #1;
    check("mid_rst_enable_pre", {63'd0, bus.eng_enable}, 64'd1);
    bus.eng_mem_operation = MEM_WRITE; bus.eng_addr = 32'd30; bus.eng_wdata = 32'h55;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.eng_mem_operation = MEM_NONE;
    seen = bus.eng_opdone;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | bus.eng_opdone;
    end
    check("mid_rst_no_opdone", {63'd0, seen}, 64'd0);
    check("mid_rst_enable", {63'd0, bus.eng_enable}, 64'd0);
    host_read_chk("mid_rst_word30", 32'd30, 32'h33);
    host_read_chk("mid_rst_status", CTRL_ADDR, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_scratchpad.md
# matrix_scratchpad

Shared operand/result memory in front of the matrix multiplication engine. Serves the engine's `mem_operation`/`mem_opdone` port and a host load/readback port from one single-port RAM, with fixed access latency and engine-priority arbitration. Also owns the go/done handshake: host writes parameter word 5 to start the engine, and the engine's `done` is captured into a status word.

## Interface
- `DEPTH`, 256: RAM words; valid addresses are 0..DEPTH-1.
- `ACCESS_LAT`, 2: cycles from grant to `ack`/`opdone`; legal range 1..8.
- Data width is `` `TYPE_BW `` (codebase-wide define).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `host_req` in 1: host access request; held until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in 32: word address.
- `host_wdata` in TYPE_BW: write data.
- `host_rdata` out TYPE_BW: read data; valid with `host_ack`, then held.
- `host_ack` out 1: one-cycle completion pulse.
- `eng_mem_operation` in 2: engine request; 00 none, 01 read, 11 write, 10 treated as none.
- `eng_addr` in 32: engine word address.
- `eng_wdata` in TYPE_BW: engine write data (engine `data_o`).
- `eng_rdata` out TYPE_BW: engine read data (engine `data_i`); held until the next engine read completes.
- `eng_opdone` out 1: one-cycle completion pulse (engine `mem_opdone`).
- `eng_enable` out 1: engine enable.
- `eng_done` in 1: engine `done`.

## Operation
- Reset values:
  - Outputs: `host_rdata`=0, `host_ack`=0, `eng_rdata`=0, `eng_opdone`=0, `eng_enable`=0.
  - Internal: busy=0, done_flag=0, FSM=IDLE.
  - RAM contents are not cleared.
- FSM states:
  - **IDLE** samples requests each cycle.
    - Engine request pending: go to ENG_ACCESS.
    - Otherwise host request pending: go to HOST_ACCESS.
    - Engine always wins a same-cycle tie.
  - **ENG_ACCESS / HOST_ACCESS**:
    - Latch op, address and write data at grant.
    - Count ACCESS_LAT cycles, then pulse the matching ack/opdone and return to IDLE.
- Engine request abort:
  - Abort applies if, during ENG_ACCESS, `eng_mem_operation` drops to 00/10 or `eng_addr` differs from the latched address.
  - Effect: return to IDLE with no `opdone` and no RAM write.
  - This covers the engine's parameter-fetch exit, which presents read@5 for one cycle and then withdraws it.
- Back-to-back engine requests:
  - The engine changes `eng_addr` on the cycle after `opdone` while holding op=01.
  - IDLE treats this as a new request. No "op went through 00" requirement.
- Address map:
  - Words 0..4 are engine parameters: op, width A, height A, width B, height B. They are plain RAM words.
  - Word 5 is control/status.
  - Matrices start at 6.
- Host write to word 5:
  - Nonzero value while busy=0: set `eng_enable`=1, busy=1, done_flag=0. Value not stored.
  - Write while busy=1: dropped, ack still given.
- Host read of word 5 returns {0…, done_flag, busy}: bit1 done_flag, bit0 busy.
- `eng_done`=1 while busy=1, sampled: `eng_enable`=0, busy=0, done_flag=1 on the next edge.
- Engine reads of word 5 return RAM content (unused by the engine).
- Out-of-range address (≥ DEPTH):
  - Reads return 0.
  - Writes are dropped.
  - Ack/opdone timing is unchanged.
- Reset mid-access: access is discarded, no ack, no RAM write, `eng_enable` drops.

## Timing
- Request seen in IDLE at cycle t: grant at edge t, RAM write/read issued at t+1, ack/opdone high during cycle t+ACCESS_LAT.
- Data valid in the same cycle as ack/opdone.
- A waiting host is served no earlier than the IDLE cycle after the current engine access.
- Host starvation while the engine is busy is accepted; there is no fairness counter.
- Only one request is in flight at a time.
- Go-to-enable latency: 1 cycle after the host write-5 ack.

## Structure
- Shared defines header (extended with this block's constants):
  - `MEM_NONE`=2'b00, `MEM_READ`=2'b01, `MEM_WRITE`=2'b11.
  - Parameter word addresses 0..5.
  - `MATRIX_BASE`=6.
- Sub-module `matrix_spram`:
  - Synchronous single-port RAM, DEPTH×TYPE_BW.
  - Registered read.
  - Write-first not required.
- Top level holds the FSM, latency counter, abort compare, and control/status logic.

## Test plan
- Host writes 7 to address 20, then reads it back:
  - `host_ack` at grant+2.
  - `host_rdata`=7.
- Engine read@1 and host read@2 requested in the same cycle:
  - Engine opdone first.
  - Host ack exactly 3 cycles later (IDLE + 2).
- Engine read@5 for one cycle, then op=00:
  - No `eng_opdone`.
  - Next host read@5 (status) unaffected.
- Full run:
  - Host loads params 2,2,2,2 with A=[1,2;3,4], B=[5,6;7,8] at 6..13, then writes word 5 = 1.
  - `eng_enable` rises.
  - After engine done, words 14..17 = 19, 22, 43, 50.
  - Status read = 2'b10.
- Host write 1 to word 5 while busy:
  - Ack given, enable/busy unchanged.
- Host write to address DEPTH:
  - Ack given.
  - Read of DEPTH returns 0.
  - Word 0 unchanged.
- Reset asserted mid ENG_ACCESS:
  - No opdone.
  - `eng_enable`=0.
  - Target word unchanged.
